// File: rtl/microtile_chk_pkg.sv
// Shared types and helpers for the microtile stimulus/response checker.
package microtile_chk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCompare,
        StDone
    } state_e;

    function automatic int unsigned clamp_num(input int unsigned n, input int unsigned depth);
        return (n > depth) ? depth : n;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/microtile_vec_ram.sv
// Vector memory: DEPTH x {mask, exp, stim}, synchronous write, asynchronous read, no reset.
module microtile_vec_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [23:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [23:0]       rdata
);

    logic [23:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/microtile_vector_checker.sv
// Drives a tile from a loadable vector memory, samples its response after a settle time and
// accumulates a saturating mismatch count plus the first failing vector.
module microtile_vector_checker
    import microtile_chk_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SETTLE = 2,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_stim,
    input  logic [7:0]        load_exp,
    input  logic [7:0]        load_mask,
    input  logic [ADDR_W:0]   num_vectors,
    input  logic              start,
    input  logic              abort,
    output logic [7:0]        ui_in,
    input  logic [7:0]        uo_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [7:0]        first_fail_obs
);

    localparam int unsigned NUM_W = ADDR_W + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [NUM_W-1:0]  num_q, num_d, num_clamped;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        ui_q, ui_d;
    logic [7:0]        err_q, err_d;
    logic [ADDR_W-1:0] ffi_q, ffi_d;
    logic [7:0]        obs_q, obs_d;
    logic [23:0]       vec_rd;
    logic [7:0]        vec_stim, vec_exp, vec_mask;
    logic              idle_like, last, mismatch;

    assign idle_like   = (state_q == StIdle) || (state_q == StDone);
    assign num_clamped = NUM_W'(clamp_num(32'(num_vectors), DEPTH));
    assign last        = ({1'b0, idx_q} == (num_q - NUM_W'(1)));
    assign vec_stim    = vec_rd[7:0];
    assign vec_exp     = vec_rd[15:8];
    assign vec_mask    = vec_rd[23:16];
    assign mismatch    = ((uo_out ^ vec_exp) & vec_mask) != 8'h00;

    microtile_vec_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (load_we && idle_like),
        .waddr (load_addr),
        .wdata ({load_mask, load_exp, load_stim}),
        .raddr (idx_q),
        .rdata (vec_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = (num_clamped == '0) ? StDone : StApply;
                    end
                end
                StApply:   state_d = StSettle;
                StSettle:  if (cnt_q == '0) state_d = StCompare;
                StCompare: state_d = last ? StDone : StApply;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == StApply) || (state_q == StSettle) || (state_q == StCompare);
        done = (state_q == StDone);
        pass = (state_q == StDone) && (err_q == 8'd0);
    end

    always_comb begin
        idx_d = idx_q;
        num_d = num_q;
        cnt_d = cnt_q;
        ui_d  = ui_q;
        err_d = err_q;
        ffi_d = ffi_q;
        obs_d = obs_q;
        if (abort) begin
            // Partial results survive an abort; only the tile drive is parked.
            ui_d = 8'h00;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        num_d = num_clamped;
                        idx_d = '0;
                        err_d = 8'd0;
                        ffi_d = '0;
                        obs_d = 8'h00;
                    end
                end
                StApply: begin
                    ui_d  = vec_stim;
                    cnt_d = CNT_W'(SETTLE - 1);
                end
                StSettle: begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                end
                StCompare: begin
                    if (mismatch) begin
                        if (err_q == 8'd0) begin
                            ffi_d = idx_q;
                            obs_d = uo_out;
                        end
                        err_d = sat_inc8(err_q);
                    end
                    if (!last) idx_d = idx_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            num_q <= '0;
            cnt_q <= '0;
            ui_q  <= 8'h00;
            err_q <= 8'd0;
            ffi_q <= '0;
            obs_q <= 8'h00;
        end else begin
            idx_q <= idx_d;
            num_q <= num_d;
            cnt_q <= cnt_d;
            ui_q  <= ui_d;
            err_q <= err_d;
            ffi_q <= ffi_d;
            obs_q <= obs_d;
        end
    end

    assign ui_in          = ui_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_obs = obs_q;

endmodule

// File: tb/tb_microtile_vector_checker.sv
// Bench for microtile_vector_checker: loopback tile, timeline model checked every cycle,
// plus directed literal expectations and a deep instance for counter saturation.
module tb_microtile_vector_checker;

    localparam int S = 2;
    localparam int P = S + 2;

    logic       clk = 1'b0;
    logic       rst, load_we, start, abort;
    logic [3:0] load_addr;
    logic [7:0] load_stim, load_exp, load_mask;
    logic [4:0] num_vectors;
    logic [7:0] ui_in, first_fail_obs, err_count;
    logic       busy, done, pass;
    logic [3:0] first_fail_idx;

    logic       b_we, b_start;
    logic [7:0] b_addr;
    logic [8:0] b_num;
    logic [7:0] b_ui, b_err, b_obs, b_ffi;
    logic       b_busy, b_done, b_pass;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cs = 0;
    int lat;

    always #5 clk = ~clk;

    microtile_vector_checker #(.DEPTH(16), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .num_vectors(num_vectors), .start(start), .abort(abort), .ui_in(ui_in),
        .uo_out(ui_in), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .first_fail_obs(first_fail_obs)
    );

    microtile_vector_checker #(.DEPTH(256), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .load_we(b_we), .load_addr(b_addr),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .num_vectors(b_num), .start(b_start), .abort(1'b0), .ui_in(b_ui),
        .uo_out(b_ui), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_fail_idx(b_ffi), .first_fail_obs(b_obs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Timeline model: a run started at edge rs applies vector j at edge rs+1+j*P and finishes
    // comparing it at edge rs+(j+1)*P; the tile is a loopback so it answers with stim[j].
    localparam int MIdle = 0, MRun = 1, MDone = 2;
    logic [7:0] m_stim [16], m_exp [16], m_mask [16];
    int         m_mode = MIdle, m_rs = 0, m_n = 0, mk, mj;
    logic [7:0] m_ui = 0, m_err = 0, m_obs = 0;
    logic [3:0] m_ffi = 0;
    bit         m_valid = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_mode != MRun && load_we === 1'b1) begin
            m_stim[load_addr] = load_stim;
            m_exp[load_addr]  = load_exp;
            m_mask[load_addr] = load_mask;
        end
        if (rst) begin
            m_valid = 1; m_mode = MIdle; m_ui = 0; m_err = 0; m_ffi = 0; m_obs = 0;
        end else if (abort) begin
            m_mode = MIdle; m_ui = 0;
        end else if (m_mode != MRun) begin
            if (start) begin
                m_n = (int'(num_vectors) > 16) ? 16 : int'(num_vectors);
                m_err = 0; m_ffi = 0; m_obs = 0;
                m_mode = (m_n == 0) ? MDone : MRun;
                m_rs = cyc;
            end
        end else begin
            mk = cyc - m_rs;
            if (mk >= 1 && (mk - 1) % P == 0 && (mk - 1) / P < m_n) m_ui = m_stim[(mk - 1) / P];
            if (mk >= P && mk % P == 0) begin
                mj = mk / P - 1;
                if (((m_stim[mj] ^ m_exp[mj]) & m_mask[mj]) != 0) begin
                    if (m_err == 0) begin m_ffi = 4'(mj); m_obs = m_stim[mj]; end
                    if (m_err != 255) m_err = m_err + 1;
                end
                if (mj == m_n - 1) m_mode = MDone;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ui_in", ui_in, m_ui);
            chk("busy", busy, m_mode == MRun);
            chk("done", done, m_mode == MDone);
            chk("pass", pass, m_mode == MDone && m_err == 0);
            chk("err_count", err_count, m_err);
            if (m_err != 0) begin
                chk("first_fail_idx", first_fail_idx, m_ffi);
                chk("first_fail_obs", first_fail_obs, m_obs);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
        load_we = 1; load_addr = 4'(a); load_stim = s; load_exp = e; load_mask = m;
        tick();
        load_we = 0;
    endtask

    task automatic go(input int n);
        num_vectors = 5'(n); start = 1;
        tick();
        start = 0; cs = cyc;
    endtask

    // Cycle number as counted from the start edge (cycle 1 is the one right after it).
    task automatic wait_done(input bit which, output int l);
        int t = 0;
        while ((which ? b_done : done) !== 1'b1 && t < 2000) begin
            tick();
            t++;
        end
        if ((which ? b_done : done) !== 1'b1) chk("wait_done_timeout", which ? b_done : done, 1);
        l = cyc - cs + 1;
    endtask

    initial begin
        rst = 1; load_we = 0; start = 0; abort = 0; load_addr = 0;
        load_stim = 0; load_exp = 0; load_mask = 0; num_vectors = 0;
        b_we = 0; b_start = 0; b_addr = 0; b_num = 0;
        tick(); tick();
        rst = 0;
        chk("reset_ui_in", ui_in, 8'h00);
        chk("reset_busy_done", {busy, done, pass}, 3'b000);
        chk("reset_err", err_count, 8'h00);

        // Four walking-one vectors, all expected to match.
        for (int i = 0; i < 4; i++) wr(i, 8'(1 << i), 8'(1 << i), 8'hFF);
        go(4);
        wait_done(0, lat);
        chk("lat_n4", lat, 17);
        chk("pass_n4", {pass, err_count}, {1'b1, 8'd0});

        wr(2, 8'h04, 8'h05, 8'hFF);
        go(4);
        wait_done(0, lat);
        chk("err_one", err_count, 8'd1);
        chk("ffi_one", first_fail_idx, 4'd2);
        chk("ffo_one", first_fail_obs, 8'h04);
        chk("pass_one", pass, 1'b0);

        wr(2, 8'h04, 8'h05, 8'hFE);
        go(4);
        wait_done(0, lat);
        chk("pass_masked", pass, 1'b1);

        // All 16 vectors fail; repeated runs must each restart the count.
        for (int i = 0; i < 16; i++) wr(i, 8'(i * 17 + 3), ~8'(i * 17 + 3), 8'hFF);
        for (int r = 0; r < 19; r++) begin
            go(16);
            chk("err_restart", err_count, 8'd0);
            wait_done(0, lat);
        end
        chk("err_16", err_count, 8'd16);
        chk("ffo_16", first_fail_obs, 8'h03);

        go(0);
        wait_done(0, lat);
        chk("lat_n0", lat, 1);
        chk("pass_n0", pass, 1'b1);

        go(20);
        wait_done(0, lat);
        chk("lat_n20", lat, 16 * P + 1);
        chk("err_n20", err_count, 8'd16);

        abort = 1; start = 1; num_vectors = 5'd4;
        tick();
        abort = 0; start = 0;
        chk("abort_over_start", {busy, done}, 2'b00);

        go(16);
        tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_ui", ui_in, 8'h00);
        chk("abort_done_busy", {done, busy}, 2'b00);

        // Reset during COMPARE; a write attempted while busy must be dropped.
        for (int i = 0; i < 4; i++) wr(i, 8'(8'h10 + i), 8'(8'h10 + i), 8'hFF);
        go(4);
        wr(1, 8'h11, 8'h77, 8'hFF);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_ui", ui_in, 8'h00);
        chk("rst_flags", {busy, done, pass}, 3'b000);
        chk("rst_results", {err_count, first_fail_obs, 4'(first_fail_idx)}, 20'h0);
        go(4);
        wait_done(0, lat);
        chk("rerun_after_rst", {pass, err_count}, {1'b1, 8'd0});

        // Deep instance: 256 failing vectors in one run saturate the counter.
        for (int i = 0; i < 256; i++) begin
            b_we = 1; b_addr = 8'(i);
            load_stim = 8'(i + 5); load_exp = ~8'(i + 5); load_mask = 8'hFF;
            tick();
        end
        b_we = 0;
        b_num = 9'd256; b_start = 1;
        tick();
        b_start = 0; cs = cyc;
        wait_done(1, lat);
        chk("b_lat", lat, 256 * 3 + 1);
        chk("b_err_sat", b_err, 8'd255);
        chk("b_ffi", b_ffi, 8'd0);
        chk("b_ffo", b_obs, 8'h05);
        chk("b_pass", b_pass, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
